add_sub_pipe: RTL and testbench
===============================

ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (>=2).
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in register stages (1..4).
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port ASYNCRESETN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port I_VALID  input  1  operand beat valid.
REQ-006 SHALL have port I_READY  output  1  block accepts beat this cycle.
REQ-007 SHALL have port OP  input  2  00 ADD, 01 SUB, 10 ADDC, 11 SUBB.
REQ-008 SHALL have port I0  input  WIDTH  first operand.
REQ-009 SHALL have port I1  input  WIDTH  second operand.
REQ-010 SHALL have port CIN  input  1  carry-in for ADDC / not-borrow for SUBB.
REQ-011 SHALL have port SAT  input  1  request signed saturation (used only when macro defined).
REQ-012 SHALL have port O_VALID  output  1  result beat valid.
REQ-013 SHALL have port O_READY  input  1  downstream accepts result.
REQ-014 SHALL have ports O  output  WIDTH  result; COUT  output  1  carry-out; OVF  output  1  signed overflow.

Function
REQ-015 SHALL compute in modulo-2^WIDTH: ADD O=I0+I1; SUB O=I0+~I1+1; ADDC O=I0+I1+CIN; SUBB O=I0+~I1+CIN.
REQ-016 SHALL set COUT to bit WIDTH of the (WIDTH+1)-bit sum; for SUB/SUBB COUT=1 means no borrow.
REQ-017 SHALL set OVF=1 when the two adder inputs (I0, effective I1) share sign and O sign differs.
REQ-018 SHALL capture the computed result in stage 1; stages 2..STAGES SHALL only delay it.
REQ-019 SHALL accept a beat when I_VALID && I_READY; I_READY = !stage1_valid || stage1 advancing.
REQ-020 SHALL advance stage k when stage k empty or stage k+1 advancing; last stage advances on O_READY.
REQ-021 SHALL present a result with O_VALID exactly STAGES cycles after acceptance when O_READY held high.
REQ-022 SHALL sustain one beat per cycle with O_READY continuously high; no bubbles inserted.
REQ-023 SHALL hold O, COUT, OVF, O_VALID stable while O_VALID && !O_READY.
REQ-024 SHALL neither drop nor duplicate beats under arbitrary O_READY toggling; order preserved.
REQ-025 SHALL, with all stages full and O_READY low, deassert I_READY the same cycle (combinational path from O_READY permitted).
REQ-026 SHALL ignore OP, I0, I1, CIN, SAT when I_VALID low.

Reset
REQ-027 SHALL on ASYNCRESETN low clear every stage valid bit immediately, O_VALID=0, O=0, COUT=0, OVF=0.
REQ-028 SHALL discard in-flight beats on reset mid-operation; first accepted beat after release follows REQ-021.
REQ-029 SHALL drive I_READY=1 out of reset once ASYNCRESETN is high.

Configuration
REQ-030 SHALL, with ADD_SUB_PIPE_SAT_EN defined, replace O by signed max (0111..1) on positive overflow or signed min (1000..0) on negative overflow when SAT=1; OVF still reports the raw overflow.
REQ-031 SHALL, without ADD_SUB_PIPE_SAT_EN, ignore SAT entirely; O always wraps.

Structure
REQ-032 SHALL place op-code enum (ADD/SUB/ADDC/SUBB) and op width constant in shared package add_sub_pkg.
REQ-033 SHALL use one sub-module add_sub_core: combinational WIDTH adder producing O, COUT, OVF (and saturation when enabled).

Verification (WIDTH=8, STAGES=2)
REQ-034 SHALL cover: ADD I0=0x7F I1=0x01 -> O=0x80, COUT=0, OVF=1, O_VALID 2 cycles after accept.
REQ-035 SHALL cover: SUB I0=0x05 I1=0x07 -> O=0xFE, COUT=0; SUBB I0=0x05 I1=0x03 CIN=0 -> O=0x01, COUT=1.
REQ-036 SHALL cover: ADDC I0=0xFF I1=0x00 CIN=1 -> O=0x00, COUT=1, OVF=0.
REQ-037 SHALL cover: 10 back-to-back beats, O_READY low cycles 3-6 -> I_READY low while full, all 10 results in order, none lost.
REQ-038 SHALL cover: macro defined, SAT=1, ADD 0x7F+0x01 -> O=0x7F; SUB 0x80-0x01 -> O=0x80; SAT=0 -> wraps.
REQ-039 SHALL cover: ASYNCRESETN low with 2 beats in flight -> O_VALID=0 same cycle, no stale result after release.

Source files
------------

// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared op-code enum, op width and adder helper functions
package add_sub_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDC = 2'b10,
        OP_SUBB = 2'b11
    } op_e;

    // Subtracting ops feed the adder with the inverted second operand.
    function automatic logic op_is_sub(input op_e op);
        return (op == OP_SUB) || (op == OP_SUBB);
    endfunction

    // Carry into the LSB: fixed for ADD/SUB, taken from CIN for the chained ops.
    function automatic logic op_carry(input op_e op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/add_sub_core.sv
// rtl/add_sub_core.sv - combinational add/sub with carry-out, overflow and optional saturation (ADD_SUB_PIPE_SAT_EN)
module add_sub_core
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sat_i,
    output logic [WIDTH-1:0] o_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    op_e              op;
    logic [WIDTH-1:0] b_eff;
    logic             carry;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] raw;

    assign op = op_e'(op_i);

    // One (WIDTH+1)-bit adder serves all four ops; overflow is judged on the adder inputs.
    always_comb begin
        b_eff  = op_is_sub(op) ? ~b_i : b_i;
        carry  = op_carry(op, cin_i);
        sum    = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry};
        raw    = sum[WIDTH-1:0];
        cout_o = sum[WIDTH];
        ovf_o  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]);
    end

`ifdef ADD_SUB_PIPE_SAT_EN
    // On overflow both inputs share a sign, so the sign of a_i tells the clamp direction.
    always_comb begin
        o_o = raw;
        if (sat_i && ovf_o) begin
            o_o = a_i[WIDTH-1] ? SMIN : SMAX;
        end
    end
`else
    logic unused_sat;
    logic [2*WIDTH-1:0] unused_lim;
    assign unused_sat = sat_i;
    assign unused_lim = {SMAX, SMIN};
    assign o_o = raw;
`endif

endmodule

// File: rtl/add_sub_pipe.sv
// rtl/add_sub_pipe.sv - elastic add/sub pipeline, STAGES deep, optional saturation via ADD_SUB_PIPE_SAT_EN
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [OP_W-1:0]  OP,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             CIN,
    input  logic             SAT,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             OVF
);

    // Each stage carries {ovf, cout, o}.
    localparam int DW = WIDTH + 2;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [DW-1:0]     data_q [STAGES];
    logic [DW-1:0]     data_d [STAGES];
    logic [STAGES-1:0] adv;

    logic [WIDTH-1:0]  core_o;
    logic              core_cout;
    logic              core_ovf;

    add_sub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i   (OP),
        .a_i    (I0),
        .b_i    (I1),
        .cin_i  (CIN),
        .sat_i  (SAT),
        .o_o    (core_o),
        .cout_o (core_cout),
        .ovf_o  (core_ovf)
    );

    // A stage advances if it or any stage downstream of it has a hole, or the sink takes the head.
    always_comb begin
        logic hole;
        hole = O_READY;
        adv  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            hole   = hole | ~valid_q[k];
            adv[k] = hole;
        end
    end

    // Stage 1 captures the adder result; later stages only shift it along.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv[0]) begin
            valid_d[0] = I_VALID;
            if (I_VALID) begin
                data_d[0] = {core_ovf, core_cout, core_o};
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    // Pipeline registers; reset empties every stage and zeroes the result.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign I_READY = adv[0];
    assign O_VALID = valid_q[STAGES-1];
    assign O       = data_q[STAGES-1][WIDTH-1:0];
    assign COUT    = data_q[STAGES-1][WIDTH];
    assign OVF     = data_q[STAGES-1][WIDTH+1];

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb/tb_add_sub_pipe.sv - scoreboard bench for add_sub_pipe with directed vectors
module tb_add_sub_pipe;

    logic       CLK;
    logic       ASYNCRESETN;
    logic       I_VALID;
    logic       I_READY;
    logic [1:0] OP;
    logic [7:0] I0;
    logic [7:0] I1;
    logic       CIN;
    logic       SAT;
    logic       O_VALID;
    logic       O_READY;
    logic [7:0] O;
    logic       COUT;
    logic       OVF;

    add_sub_pipe #(
        .WIDTH  (8),
        .STAGES (2)
    ) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .I_VALID     (I_VALID),
        .I_READY     (I_READY),
        .OP          (OP),
        .I0          (I0),
        .I1          (I1),
        .CIN         (CIN),
        .SAT         (SAT),
        .O_VALID     (O_VALID),
        .O_READY     (O_READY),
        .O           (O),
        .COUT        (COUT),
        .OVF         (OVF)
    );

    typedef struct {
        logic [7:0] o;
        logic       c;
        logic       v;
        bit         lat;
        int         c0;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    bit   held = 0;
    logic [10:0] held_val;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted. I_VALID stays high.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sat,
                        input logic [7:0] eo, input logic ec, input logic ev, input bit lat);
        exp_t e;
        int   n;
        I_VALID = 1'b1; OP = op; I0 = a; I1 = b; CIN = cin; SAT = sat;
        n = 0;
        forever begin
            @(negedge CLK);
            if (I_READY) begin
                e.o = eo; e.c = ec; e.v = ev; e.lat = lat; e.c0 = cyc;
                sb.push_back(e);
                @(posedge CLK); #1;
                return;
            end
            n++;
            if (n > 50) begin
                chk("accept_timeout", 32'(n), 0);
                @(posedge CLK); #1;
                return;
            end
            @(posedge CLK); #1;
        end
    endtask

    // Drop valid and scramble the operand bus; nothing may come out of it.
    task automatic idle(input int cycles);
        I_VALID = 1'b0;
        OP = 2'($urandom); I0 = 8'($urandom); I1 = 8'($urandom);
        CIN = 1'($urandom); SAT = 1'($urandom);
        repeat (cycles) @(posedge CLK);
        #1;
    endtask

    // Monitor: pop on every output transfer, and check holding while stalled.
    always @(negedge CLK) begin
        exp_t e;
        if (!ASYNCRESETN) begin
            held = 0;
        end else begin
            if (held) chk("stall_hold", {21'd0, O_VALID, OVF, COUT, O}, {21'd0, held_val});
            if (O_VALID && O_READY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {24'd0, O}, 32'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("result", {22'd0, O, COUT, OVF}, {22'd0, e.o, e.c, e.v});
                    if (e.lat) chk("latency", 32'(cyc - e.c0), 32'd2);
                end
                held = 0;
            end else if (O_VALID) begin
                held = 1;
                held_val = {O_VALID, OVF, COUT, O};
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ASYNCRESETN = 1'b0;
        O_READY = 1'b1;
        I_VALID = 1'b0; OP = 2'b00; I0 = 8'h00; I1 = 8'h00; CIN = 1'b0; SAT = 1'b0;
        #3;
        chk("rst_o_valid", {31'd0, O_VALID}, 0);
        chk("rst_o", {24'd0, O}, 0);
        chk("rst_cout_ovf", {30'd0, COUT, OVF}, 0);
        repeat (2) @(posedge CLK);
        #1 ASYNCRESETN = 1'b1;
        #1 chk("rst_i_ready", {31'd0, I_READY}, 1);
        @(posedge CLK); #1;

        // Directed vectors: op, a, b, cin, sat, expected o/cout/ovf, latency check.
        send(2'b00, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1); idle(4);
        send(2'b01, 8'h05, 8'h07, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1); idle(4);
        send(2'b11, 8'h05, 8'h03, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1); idle(4);
        send(2'b10, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1); idle(4);
        send(2'b00, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1); idle(4);
`ifdef ADD_SUB_PIPE_SAT_EN
        send(2'b00, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1); idle(4);
        send(2'b01, 8'h80, 8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1); idle(4);
`else
        send(2'b00, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1); idle(4);
        send(2'b01, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1); idle(4);
`endif
        send(2'b01, 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 1); idle(4);

        // Ten back-to-back ADDs (i*16 + i = i*17), sink stalled in cycles 3..6.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(2'b00, 8'(i * 16), 8'(i), 1'b0, 1'b0, 8'(i * 17), 1'b0, 1'b0, 0);
                end
                idle(1);
            end
            begin
                repeat (3) @(posedge CLK);
                #1 O_READY = 1'b0;
                repeat (4) begin
                    @(negedge CLK);
                    chk("full_i_ready", {31'd0, I_READY}, 0);
                end
                @(posedge CLK);
                #1 O_READY = 1'b1;
            end
        join
        idle(6);

        // Two beats in flight, then reset mid-cycle.
        O_READY = 1'b0;
        send(2'b00, 8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 0);
        send(2'b00, 8'h44, 8'h11, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 0);
        I_VALID = 1'b0;
        #1 ASYNCRESETN = 1'b0;
        #1;
        chk("midrst_o_valid", {31'd0, O_VALID}, 0);
        chk("midrst_o", {24'd0, O}, 0);
        sb.delete();
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        O_READY = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            chk("no_stale", {31'd0, O_VALID}, 0);
        end
        @(posedge CLK); #1;
        send(2'b10, 8'h01, 8'h01, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1);
        idle(8);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
